// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Stores push bytes into a FIFO; a bit-timer driven FSM serializes them onto txd.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | txd=1, waiting for enable and a non-empty FIFO
// START | txd=0 for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | txd=1 for one bit period, then back to IDLE
module dbus_uart_tx #(
  parameter int          FIFO_AW   = 4,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic [31:0] in,
  input  logic        we,
  output logic [31:0] out,
  output logic        txd
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;

  logic               overflow;
  logic               enable;
  logic [15:0]        baud_div;

  state_t             state;
  logic [7:0]         shreg;
  logic [2:0]         bit_idx;
  logic [15:0]        timer;
  logic [15:0]        div_lat;

  logic [1:0]         reg_sel;
  logic               wr;
  logic               full;
  logic               empty;
  logic               busy;
  logic               pop;
  logic               push_req;
  logic               push;
  logic               ovf_set;
  logic               ovf_clr;
  logic [31:0]        rdata;

  assign reg_sel  = addr[3:2];
  assign wr       = sel & we;
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign pop      = (state == IDLE) & enable & ~empty;
  assign push_req = wr & (reg_sel == REG_TXDATA);
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = wr & (reg_sel == REG_CONTROL) & in[1];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      enable   <= 1'b0;
      baud_div <= DIV_RESET;
    end else begin
      if (wr && (reg_sel == REG_BAUDDIV)) begin
        baud_div <= (in[15:0] == 16'd0) ? 16'd1 : in[15:0];
      end
      if (wr && (reg_sel == REG_CONTROL)) begin
        enable <= in[0];
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: begin
        rdata[0]             = full;
        rdata[1]             = empty;
        rdata[2]             = busy;
        rdata[3]             = overflow;
        rdata[8 +: FIFO_AW+1] = count;
      end
      REG_BAUDDIV: rdata[15:0] = baud_div;
      REG_CONTROL: rdata[0]    = enable;
      default:     rdata       = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else begin
      out <= (sel && !we) ? rdata : '0;
    end
  end

  // div_lat freezes the bit period for the whole frame; BAUDDIV writes wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
      timer   <= '0;
      div_lat <= DIV_RESET;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shreg   <= mem[rptr];
            div_lat <= baud_div;
            timer   <= baud_div - 16'd1;
            txd     <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (timer == 16'd0) begin
            timer   <= div_lat - 16'd1;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DATA: begin
          if (timer == 16'd0) begin
            timer <= div_lat - 16'd1;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        STOP: begin
          if (timer == 16'd0) begin
            state <= IDLE;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Bench for dbus_uart_tx: bus tasks drive the register map, a line monitor
// decodes each 8N1 frame from txd and compares it with a queue of expected bytes.
module tb_dbus_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] bus_in;
  logic        we;
  logic [31:0] bus_out;
  logic        txd;

  dbus_uart_tx #(.FIFO_AW(4), .DIV_RESET(16'd868)) dut (
    .clk  (clk),
    .rst  (rst_n),
    .sel  (sel),
    .addr (addr),
    .in   (bus_in),
    .we   (we),
    .out  (bus_out),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // expected-frame model
  logic [7:0] exp_q[$];
  int         starts_q[$];
  int         frames_done = 0;
  int         frame_div = 4;
  bit         mon_en = 1'b1;
  int         last_wr_cyc;

  task automatic bus_idle_noise();
    addr   = $urandom();
    bus_in = $urandom();
    we     = 1'($urandom_range(0, 1));
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] a;
    a = $urandom();
    a[3:2] = r;
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; bus_in = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    last_wr_cyc = cyc;
    check("wr_out_zero", bus_out, 32'd0);
    bus_idle_noise();
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
    logic [31:0] a;
    a = $urandom();
    a[3:2] = r;
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = bus_out;
    sel = 1'b0;
    bus_idle_noise();
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(2'd0, {24'd0, b});
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frames_done", frames_done, target);
  endtask

  // Line monitor: each bit period must hold one level; start=0, stop=1.
  int         m_d;
  int         m_sc;
  logic [9:0] m_lv;
  bit         m_ok;
  bit         m_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && txd === 1'b0) begin
        m_d = frame_div; m_sc = cyc; m_lv = '1; m_lv[0] = 1'b0; m_ok = 1'b1; m_abort = 1'b0;
        for (int i = 1; i < 10 * m_d; i++) begin
          @(negedge clk);
          if (!mon_en || !rst_n) begin
            m_abort = 1'b1;
            break;
          end
          if (i % m_d == 0) m_lv[i / m_d] = txd;
          else if (txd !== m_lv[i / m_d]) m_ok = 1'b0;
        end
        if (!m_abort) begin
          check("frame_shape", {29'd0, m_ok, m_lv[0], m_lv[9]}, 32'd5);
          if (exp_q.size() == 0) check("frame_unexpected", {24'd0, m_lv[8:1]}, 32'hFFFF_FFFF);
          else check("frame_byte", {24'd0, m_lv[8:1]}, {24'd0, exp_q.pop_front()});
          starts_q.push_back(m_sc);
          frames_done++;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          f, d, n;

    rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; bus_in = '0;

    // reset and idle
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_out", bus_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_txd", {31'd0, txd}, 32'd1);
    bus_read(2'd1, rd); check("rst_status", rd, 32'h0000_0002);
    bus_read(2'd2, rd); check("rst_bauddiv", rd, 32'd868);
    bus_read(2'd3, rd); check("rst_control", rd, 32'd0);
    bus_read(2'd0, rd); check("txdata_reads_zero", rd, 32'd0);

    // single frame 0xA5 at DIV=4, earliest start
    bus_write(2'd2, 32'd4); frame_div = 4;
    bus_write(2'd3, 32'd1);
    push_byte(8'hA5);
    f = last_wr_cyc;
    bus_read(2'd1, rd); check("busy_in_frame", {31'd0, rd[2]}, 32'd1);
    wait_frames(1, 100);
    check("first_start_lat", starts_q[starts_q.size()-1] - f, 32'd1);
    bus_read(2'd1, rd); check("status_after_frame", rd, 32'h0000_0002);

    // clearing enable mid-frame finishes the frame, then holds
    f = frames_done;
    push_byte(8'h11);
    push_byte(8'h22);
    bus_write(2'd3, 32'd0);
    wait_frames(f + 1, 100);
    repeat (60) @(negedge clk);
    check("en_off_hold", frames_done, f + 1);
    bus_read(2'd1, rd); check("en_off_status", rd, 32'h0000_0100);
    bus_write(2'd3, 32'd1);
    wait_frames(f + 2, 100);

    // BAUDDIV change during a frame applies to the next frame
    f = frames_done;
    push_byte(8'h3C);
    repeat (8) @(negedge clk);
    bus_write(2'd2, 32'd3);
    wait_frames(f + 1, 100);
    frame_div = 3;
    bus_read(2'd2, rd); check("bauddiv_rw", rd, 32'd3);
    push_byte(8'hC3);
    wait_frames(f + 2, 100);

    // fill and overflow with enable off
    bus_write(2'd3, 32'd0);
    bus_write(2'd2, 32'd4); frame_div = 4;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom());
      push_byte(b);
    end
    bus_read(2'd1, rd); check("status_full", rd, 32'h0000_1001);
    bus_write(2'd0, 32'h77);
    bus_read(2'd1, rd); check("status_overflow", rd, 32'h0000_1009);
    bus_write(2'd3, 32'h2);
    bus_read(2'd1, rd); check("overflow_cleared", rd, 32'h0000_1001);

    // enable, then push in the very cycle the head pops
    f = frames_done;
    b = 8'($urandom());
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 32'h0000_000C; bus_in = 32'd1;
    @(negedge clk);
    addr = 32'h0000_0000; bus_in = {24'd0, b};
    exp_q.push_back(b);
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    bus_read(2'd1, rd); check("push_pop_full", rd, 32'h0000_1005);
    wait_frames(f + 17, 17 * 45);
    bus_read(2'd1, rd); check("drained_status", rd, 32'h0000_0002);

    // back-to-back at DIV=2
    bus_write(2'd2, 32'd2); frame_div = 2;
    f = frames_done;
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(f + 2, 100);
    check("b2b_spacing", starts_q[starts_q.size()-1] - starts_q[starts_q.size()-2], 32'd21);
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, rd); check("bauddiv_zero_is_one", rd, 32'd1);

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      d = $urandom_range(1, 6);
      bus_write(2'd2, d); frame_div = d;
      n = $urandom_range(2, 6);
      f = frames_done;
      for (int k = 0; k < n; k++) begin
        push_byte(8'($urandom()));
        repeat ($urandom_range(0, 12 * d)) @(negedge clk);
      end
      wait_frames(f + n, n * (10 * d + 1) + 200);
    end
    check("exp_q_empty", exp_q.size(), 32'd0);
    bus_read(2'd1, rd); check("random_end_status", rd, 32'h0000_0002);

    // reset in the middle of a frame
    mon_en = 1'b0;
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h00);
    repeat (10) @(negedge clk);
    check("txd_before_rst", {31'd0, txd}, 32'd0);
    #1 rst_n = 1'b0;
    #1 check("rst_async_txd", {31'd0, txd}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus_read(2'd1, rd); check("post_rst_status", rd, 32'h0000_0002);
    bus_read(2'd3, rd); check("post_rst_control", rd, 32'd0);
    bus_read(2'd2, rd); check("post_rst_bauddiv", rd, 32'd868);
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1) n++;
    end
    check("post_rst_no_frame", n, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbus_uart_tx.md
# dbus_uart_tx

Memory-mapped UART transmitter that responds on the processor's data-memory bus, the same addr/in/we/out word interface with registered one-cycle read data that the pipeline's MM stage drives toward `dmem`. The processor stores bytes into a transmit FIFO and polls status through loads. The block serializes the bytes as 8N1 frames on `txd`. It sits beside `dmem` on the data bus, selected by an external address decode.

## Interface
- `FIFO_AW`, default 4: FIFO address width; depth = 2**FIFO_AW entries of 8 bits.
- `DIV_RESET`, default 16'd868: reset value of the baud divisor, in clock cycles per bit.
- `clk` input 1: the single clock; everything is rising-edge.
- `rst` input 1: reset, asynchronous and active-low (0 = reset).
- `sel` input 1: block selected by the external decode for this bus cycle.
- `addr` input 32: byte address. Only `addr[3:2]` is decoded; the other bits are ignored.
- `in` input 32: write data (the store's rt value).
- `we` input 1: write strobe, qualified by `sel`.
- `out` output 32: read data, registered, valid one cycle after the address.
- `txd` output 1: serial output; idle level is 1.

## Operation
- Register map by `addr[3:2]`:
  - 0 TXDATA. A write pushes `in[7:0]`. Reads return 0.
  - 1 STATUS, read-only:
    - bit0 full
    - bit1 empty
    - bit2 busy (FSM not IDLE)
    - bit3 overflow (sticky)
    - bits[8+:FIFO_AW+1] count
    - all other bits 0
  - 2 BAUDDIV: bits[15:0] are read/write. A write of 0 is stored as 1.
  - 3 CONTROL: bit0 enable, read/write, resets to 0. Writing 1 to bit1 clears overflow; bit1 always reads 0.
- Reads have no side effects.
- `out` = 0 when the block was not selected in the prior cycle, or during a write cycle.
- FIFO:
  - Circular buffer with FIFO_AW-bit read and write pointers that wrap modulo depth.
  - `count` is FIFO_AW+1 bits, range 0..depth.
  - Push when full: dropped and overflow set, unless a pop occurs in the same cycle, in which case the push is accepted and count is unchanged.
  - Push and pop in the same non-full, non-empty cycle: count is unchanged.
  - Overflow set and overflow clear in the same cycle: set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE, with enable=1 and FIFO not empty: pop the head into the shift register, latch BAUDDIV into the bit-period counter reload, go to START.
  - START: `txd`=0 for DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held DIV cycles. A 3-bit bit index counts 0..7, then go to STOP.
  - STOP: `txd`=1 for DIV cycles, then go to IDLE.
  - The bit timer is a 16-bit down-counter loaded with DIV-1 at each bit start; the bit advances when the timer reaches 0.
- Mid-frame changes:
  - A BAUDDIV write during a frame takes effect at the next frame.
  - Clearing enable during a frame completes the current frame, then the FSM stays in IDLE.

## Timing
- Reset values while `rst`=0, asynchronous:
  - `out`=0, `txd`=1
  - FSM in IDLE, pointers and count 0
  - overflow 0, enable 0, BAUDDIV=DIV_RESET
- Reset mid-frame forces `txd`=1 immediately. Contents of the FIFO and shift register are discarded.
- Write latency: a write in cycle N updates the register or FIFO at edge N. A STATUS read issued in cycle N+1 returns the updated value on `out` in cycle N+2.
- Read latency: the address is presented in cycle N and `out` is valid in cycle N+1, matching `dmem`.
- Pop occurs at the edge ending the IDLE cycle. `txd` falls at that same edge, so START begins the following cycle.
- Frame length is 10·DIV cycles. Back-to-back frames have exactly one IDLE cycle between the STOP end and the next START, so the period is 10·DIV+1 cycles.
- Earliest first start bit: a push at edge N with enable already 1 gives IDLE-with-data in cycle N+1, and `txd`=0 from edge N+1.

## Test plan
- Reset and idle:
  - Stimulus: release `rst`.
  - Response: `txd`=1. STATUS read = 0x0000_0002 (empty, count 0). BAUDDIV read = 868.
- Single frame:
  - Stimulus: BAUDDIV=4, CONTROL=1, TXDATA=0xA5.
  - Response: `txd` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total). STATUS busy=1 during the frame and 0 after it.
- Fill and overflow (FIFO_AW=4), with enable=0:
  - Push 16 bytes → STATUS = full|count 16 (0x0000_1001).
  - 17th push → overflow bit3 set, count stays 16.
  - CONTROL write 0x2 → overflow cleared.
- Simultaneous push and pop at full:
  - Stimulus: full FIFO, enable=1, a push in the pop cycle.
  - Response: count stays 16, overflow stays 0, the pushed byte is transmitted last.
- Back-to-back frames:
  - Stimulus: DIV=2, push 0x00 and 0xFF.
  - Response: the second start bit begins 21 cycles after the first. BAUDDIV=0 write reads back 1.
- Reset mid-frame:
  - Stimulus: assert `rst` during DATA.
  - Response: `txd`=1 immediately, not on a clock edge. After release: STATUS=0x2, enable=0, no further frame is sent.
